// File: rtl/mips_muldiv_pkg.sv
// Shared multiply/divide op codes and small op-class helpers.
// Used by the core's decode and by mips_muldiv.
package mips_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle on operand magnitudes, sign fix-up in a final FIX cycle.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] acc;
    logic               is_div, neg_res, neg_rem, dbz_op;

    logic               a_neg, b_neg, accept, fits;
    logic [WIDTH-1:0]   abs_a, abs_b, addend, rem_sub, quo_fix, rem_fix;
    logic [WIDTH:0]     sum, shifted;
    logic [2*WIDTH-1:0] prod_fix;

    assign busy   = ~ready;
    assign accept = start & ready;

    assign a_neg = md_is_signed(op) & op_a[WIDTH-1];
    assign b_neg = md_is_signed(op) & op_b[WIDTH-1];
    assign abs_a = a_neg ? -op_a : op_a;
    assign abs_b = b_neg ? -op_b : op_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign addend = acc[0] ? mag : '0;
    assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // Divide: acc[WIDTH-1:0] shifts the dividend out and the quotient in.
    assign shifted = {rem, acc[WIDTH-1]};
    assign fits    = shifted >= {1'b0, mag};
    assign rem_sub = shifted[WIDTH-1:0] - mag;

    // A zero divisor always "fits", so the quotient ends all-ones and the
    // remainder ends as |op_a|, which the dividend-sign fix turns back into op_a.
    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = dbz_op ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem_fix  = neg_rem ? -rem : rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mag         <= '0;
            rem         <= '0;
            acc         <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dbz_op      <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_by_zero <= 1'b0;
                        if (op == MD_MTHI) begin
                            hi   <= op_a;
                            done <= 1'b1;
                        end else if (op == MD_MTLO) begin
                            lo   <= op_a;
                            done <= 1'b1;
                        end else if (md_is_arith(op)) begin
                            state   <= S_RUN;
                            ready   <= 1'b0;
                            cnt     <= '0;
                            rem     <= '0;
                            is_div  <= md_is_div(op);
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            dbz_op  <= md_is_div(op) && (op_b == '0);
                            if (md_is_div(op)) begin
                                mag <= abs_b;
                                acc <= {{WIDTH{1'b0}}, abs_a};
                            end else begin
                                mag <= abs_a;
                                acc <= {{WIDTH{1'b0}}, abs_b};
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (is_div) begin
                            rem            <= fits ? rem_sub : shifted[WIDTH-1:0];
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], fits};
                        end else begin
                            acc <= {sum, acc[WIDTH-1:1]};
                        end
                        if (cnt == CW'(WIDTH - 1))
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    if (!abort) begin
                        done <= 1'b1;
                        if (dbz_op)
                            div_by_zero <= 1'b1;
                        if (is_div) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: transaction-level model checked every cycle on the
// 32-bit instance, plus directed literal checks on 32- and 8-bit instances.
module tb_mips_muldiv;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        ready, busy, done, dbz;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0, abort8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .abort(abort), .ready(ready), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(dbz)
    );

    mips_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .op_a(a8), .op_b(b8),
        .abort(abort8), .ready(ready8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
        .div_by_zero(dbz8)
    );

    // Result of an arithmetic op as {div_by_zero, hi, lo}, from plain integer arithmetic.
    function automatic logic [64:0] md_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        p = '0; q = '0; r = '0;
        case (o)
            MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
            MD_MULT:  begin p = sa * sb; return {1'b0, p}; end
            MD_DIVU:  begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic        m_ready, m_done, m_dbz;
    logic [64:0] p_res;
    int          m_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_ready <= 1'b1; m_done <= 1'b0; m_dbz <= 1'b0;
            m_left <= 0; p_res <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_ready) begin
                if (abort) begin
                    m_ready <= 1'b1;
                end else if (m_left == 1) begin
                    m_dbz   <= p_res[64];
                    m_hi    <= p_res[63:32];
                    m_lo    <= p_res[31:0];
                    m_done  <= 1'b1;
                    m_ready <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start) begin
                m_dbz <= 1'b0;
                case (op)
                    MD_MTHI: begin m_hi <= op_a; m_done <= 1'b1; end
                    MD_MTLO: begin m_lo <= op_a; m_done <= 1'b1; end
                    MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        p_res   <= md_model(op, op_a, op_b);
                        m_left  <= 33;
                        m_ready <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ({hi, lo, ready, busy, done, dbz} !== {m_hi, m_lo, m_ready, ~m_ready, m_done, m_dbz}) begin
                errors++;
                $display("FAIL model @%0t: got hi=%h lo=%h rdy=%b busy=%b done=%b dbz=%b expected hi=%h lo=%h rdy=%b done=%b dbz=%b",
                         $time, hi, lo, ready, busy, done, dbz, m_hi, m_lo, m_ready, m_done, m_dbz);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < 100);
    endtask

    task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        start8 = 1'b1; op8 = o; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done8 && cyc < 100);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int seen;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_flags", {60'h0, ready, busy, done, dbz}, {60'h0, 4'b1000});
        chk("reset_ready8", {63'h0, ready8}, 64'h1);
        reset = 1'b0;

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("multu_latency", 64'(cyc), 64'd33);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(MD_DIVU, 32'd7, 32'd0);
        wait_done(cyc);
        chk("divu_zero_res", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        chk("divu_zero_flag", {63'h0, dbz}, 64'h1);

        issue(MD_MULTU, 32'd6, 32'd7);
        chk("dbz_cleared", {63'h0, dbz}, 64'h0);
        wait_done(cyc);
        chk("multu_6x7", {hi, lo}, 64'd42);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
        chk("div_overflow_flag", {63'h0, dbz}, 64'h0);

        // Back-to-back MT ops
        @(posedge clk); #1;
        start = 1'b1; op = MD_MTHI; op_a = 32'h1234;
        @(posedge clk); #1;
        chk("mthi_done", {63'h0, done}, 64'h1);
        chk("mthi_hi", 64'(hi), 64'h1234);
        op = MD_MTLO; op_a = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo_done", {63'h0, done}, 64'h1);
        chk("mt_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
        @(posedge clk); #1;
        chk("mt_done_drop", {63'h0, done}, 64'h0);

        // Abort 10 cycles into a DIVU
        issue(MD_DIVU, 32'd100, 32'd3);
        repeat (10) @(posedge clk);
        #1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ready", {62'h0, ready, busy}, 64'h2);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

        // Start pulsed while busy is ignored
        issue(MD_MULTU, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #1; start = 1'b1; op = MD_DIVU; op_a = 32'd1; op_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        chk("busy_start_latency", 64'(cyc), 64'd27);
        chk("busy_start_res", {hi, lo}, 64'd81);
        chk("busy_start_flag", {63'h0, dbz}, 64'h0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("busy_start_no_extra", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of RUN
        issue(MD_MULTU, 32'd5, 32'd5);
        repeat (8) @(posedge clk);
        #4; reset = 1'b1;
        #1;
        chk("async_reset_hilo", {hi, lo}, 64'h0);
        chk("async_reset_flags", {60'h0, ready, busy, done, dbz}, {60'h0, 4'b1000});
        @(posedge clk); #1;
        reset = 1'b0;
        issue(MD_MULTU, 32'd6, 32'd7);
        wait_done(cyc);
        chk("post_reset_latency", 64'(cyc), 64'd33);
        chk("post_reset_6x7", {hi, lo}, 64'd42);

        // WIDTH=8 instance
        issue8(MD_MULTU, 8'hFF, 8'hFF);
        wait_done8(cyc);
        chk("w8_latency", 64'(cyc), 64'd9);
        chk("w8_multu", {48'h0, hi8, lo8}, 64'hFE01);
        issue8(MD_DIV, 8'hF9, 8'h02);
        wait_done8(cyc);
        chk("w8_div_neg", {48'h0, hi8, lo8}, 64'hFFFD);
        issue8(MD_DIVU, 8'h07, 8'h00);
        wait_done8(cyc);
        chk("w8_divu_zero", {47'h0, dbz8, hi8, lo8}, 64'h107FF);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
